prio_drain_enc: RTL and testbench
=================================

PRIO_DRAIN_ENC -- requirements
Module: prio_drain_enc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning request vector width (legal range 2..64).
REQ-002 SHALL have localparam IW, default $clog2(WIDTH), meaning encoded index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port d  input  WIDTH  request vector; bit 0 = highest fixed priority.
REQ-006 SHALL have port load  input  1  merge d into pending set this cycle.
REQ-007 SHALL have port hold  input  1  freeze: no load, no pop, all state kept.
REQ-008 SHALL have port any  output  1  combinational OR of d.
REQ-009 SHALL have port out_valid  output  1  q holds a pending index.
REQ-010 SHALL have port out_ready  input  1  consumer accepts q this cycle.
REQ-011 SHALL have port q  output  IW  index of selected pending bit.
REQ-012 SHALL have port count  output  IW+1  number of pending bits (popcount).
REQ-013 SHALL have port busy  output  1  state is DRAIN.

Function
REQ-014 SHALL hold WIDTH-bit register pend and two-state FSM {IDLE, DRAIN}.
REQ-015 SHALL drive any = |d at all times, independent of hold, state and reset.
REQ-016 SHALL define pop = out_valid & out_ready & !hold, and ld = load & !hold & (d != 0).
REQ-017 SHALL update pend_next = (pend & ~(pop ? onehot(q) : 0)) | (ld ? d : 0); pop and load in the same cycle both take effect.
REQ-018 SHALL transition IDLE->DRAIN when ld; DRAIN->IDLE when pend_next == 0; else remain.
REQ-019 SHALL drive out_valid = busy = (state == DRAIN); first valid appears one cycle after ld (latency 1).
REQ-020 SHALL drive q combinationally from registered pend (and pointer, REQ-029); q = 0 when out_valid = 0.
REQ-021 SHALL keep q, pend, count and state unchanged while hold = 1, regardless of load/out_ready.
REQ-022 SHALL ignore load with d == 0; loading an already-pending bit SHALL NOT duplicate it.
REQ-023 SHALL drive count = popcount(pend); count = 0 exactly when IDLE.
REQ-024 SHALL, when the popped bit is re-requested by a same-cycle load, keep that bit pending.
REQ-025 SHALL emit each pending bit exactly once per assertion, never an index with pend bit clear.

Reset
REQ-026 SHALL, on rising clk with rst_n = 0, set pend = 0, state = IDLE, rotate pointer = 0, overriding load/hold/pop.
REQ-027 SHALL show out_valid = 0, busy = 0, q = 0, count = 0 from the first edge in reset; reset mid-drain discards all pending bits.

Configuration
REQ-028 SHALL, without PRIO_DRAIN_ENC_ROTATE_EN, select the lowest-index set bit of pend (fixed priority).
REQ-029 SHALL, with PRIO_DRAIN_ENC_ROTATE_EN defined, keep IW-bit pointer ptr (reset 0), updated to q+1 mod WIDTH on each pop, and select the first set bit at or above ptr, wrapping to index 0.
REQ-030 SHALL leave hold, unchanged ptr while hold = 1, and all other requirements identical in both builds.

Verification
REQ-031 SHALL cover: WIDTH=8, load d=8'b1010_0100, out_ready=1 -> q=2,5,7 on three consecutive cycles, then out_valid=0, count 3->2->1->0.
REQ-032 SHALL cover: draining with q=5 pending, out_ready=1, load d=8'b0000_0001 same cycle -> next q=0 (fixed) / q=7 (rotate build), count stays 2.
REQ-033 SHALL cover: out_valid=1, q=3, hold=1 for 4 cycles with out_ready=1 and load d=8'hFF -> q=3, count unchanged; release -> pop resumes.
REQ-034 SHALL cover: rst_n=0 for one cycle while count=5 -> next cycle out_valid=0, count=0, q=0; any still tracks d.
REQ-035 SHALL cover: rotate build, d=8'b1000_0011 loaded, pop q=0, reload d=8'b0000_0001 same cycle -> sequence q=0,1,7,0.
REQ-036 SHALL cover: WIDTH=5, load d=5'b10000, out_ready=0 for 3 cycles -> q=4 stable, out_valid=1; out_ready=1 -> IDLE next cycle.

Source files
------------

// File: rtl/prio_drain_enc.sv
// prio_drain_enc: latches request vectors into a pending set and drains
// it one index per accepted handshake. Bit 0 has the highest fixed priority.
//
// Optional build macro PRIO_DRAIN_ENC_ROTATE_EN: selection starts at a
// rotating pointer (one past the last popped index), wrapping to index 0.
// If the macro is not defined, the lowest set bit always wins.
//
// Reset is synchronous and active-low.
module prio_drain_enc #(
    parameter  int WIDTH = 8,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             hold,
    output logic             any,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    q,
    output logic [IW:0]      count,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] pop_mask;
    logic [IW-1:0]    sel_idx;
    logic             pop;
    logic             ld;

    // Index of the lowest set bit of vec. Returns 0 for an empty vector,
    // which is harmless because callers only use it while pend is non-empty.
    function automatic logic [IW-1:0] lowest_set(input logic [WIDTH-1:0] vec);
        lowest_set = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set = IW'(i);
            end
        end
    endfunction

    // Request-present flag: purely combinational, ignores hold, state and reset.
    assign any = |d;

    // Handshake qualifiers. hold blocks both pop and load, freezing all state.
    assign pop = out_valid & out_ready & ~hold;
    assign ld  = load & ~hold & (|d);

    // Status outputs follow the FSM state directly.
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);

`ifdef PRIO_DRAIN_ENC_ROTATE_EN

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] pend_upper;

    // Rotating selection: first pending bit at or above ptr, else wrap to
    // the lowest pending bit overall.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upper_mask[i] = (32'(i) >= 32'(ptr_q));
        end
        pend_upper = pend_q & upper_mask;
        sel_idx    = (|pend_upper) ? lowest_set(pend_upper) : lowest_set(pend_q);
    end

    // Pointer advances one past the popped index, modulo WIDTH.
    always_comb begin
        ptr_d = ptr_q;
        if (pop) begin
            ptr_d = (sel_idx == IW'(WIDTH - 1)) ? '0 : sel_idx + IW'(1);
        end
    end

    // Rotate pointer register; cleared by reset, frozen by hold through pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`else

    // Fixed priority selection: lowest-index pending bit.
    always_comb begin
        sel_idx = lowest_set(pend_q);
    end

`endif

    // Presented index is forced to zero whenever nothing is valid.
    assign q = out_valid ? sel_idx : '0;

    // Next pending set: retire the popped bit, then merge any new load so a
    // same-cycle re-request of the popped bit keeps it pending.
    always_comb begin
        pop_mask = '0;
        if (pop) begin
            pop_mask = WIDTH'(1) << sel_idx;
        end
        pend_d = pend_q & ~pop_mask;
        if (ld) begin
            pend_d = pend_d | d;
        end
    end

    // FSM next state: enter DRAIN on a load, leave once the set empties.
    always_comb begin
        // NOTE: assign the default first so every path drives state_d; a
        // missing branch in always_comb would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ld) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and pending-set registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Population count of the pending set.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + (IW + 1)'(pend_q[i]);
        end
    end

    // Structural invariants: a presented index is always pending, and the
    // pending set is empty exactly when the FSM is idle.
    a_q_is_pending: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (|(pend_q & (WIDTH'(1) << q))));

    a_idle_iff_empty: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == IDLE) == (pend_q == '0)));

endmodule

// File: tb/tb_prio_drain_enc.sv
// Self-checking bench for prio_drain_enc: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// pending set. Works for both the fixed and the rotating build.
module tb_prio_drain_enc;

    localparam int W = 8;

`ifdef PRIO_DRAIN_ENC_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       load, hold, out_ready;
    logic       any, out_valid, busy;
    logic [2:0] q;
    logic [3:0] count;

    logic [4:0] d5;
    logic       load5, hold5, ready5;
    logic       any5, valid5, busy5;
    logic [2:0] q5;
    logic [3:0] count5;

    int n_checks = 0;
    int n_pass   = 0;

    prio_drain_enc #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .load     (load),
        .hold     (hold),
        .any      (any),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
        .count    (count),
        .busy     (busy)
    );

    prio_drain_enc #(.WIDTH(5)) dut5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d5),
        .load     (load5),
        .hold     (hold5),
        .any      (any5),
        .out_valid(valid5),
        .out_ready(ready5),
        .q        (q5),
        .count    (count5),
        .busy     (busy5)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: a set of pending indices, a busy flag and a
    // rotation start point (always 0 in the fixed build).
    bit m_pend[W];
    bit m_busy;
    int m_ptr;

    function automatic int m_sel();
        for (int k = 0; k < W; k++) begin
            int idx = (m_ptr + k) % W;
            if (m_pend[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic int m_count();
        int n = 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [7:0] dd, input bit ld_i,
                              input bit hd, input bit rd);
        bit pop_m;
        bit ld_m;
        int s;
        if (!r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_busy = 1'b0;
            m_ptr  = 0;
        end else begin
            pop_m = m_busy && rd && !hd;
            ld_m  = ld_i && !hd && (dd != 8'h00);
            s     = m_sel();
            if (pop_m) begin
                m_pend[s] = 1'b0;
                if (ROT) m_ptr = (s + 1) % W;
            end
            if (ld_m) begin
                for (int i = 0; i < W; i++) if (dd[i]) m_pend[i] = 1'b1;
            end
            if (!m_busy && ld_m) m_busy = 1'b1;
            else if (m_busy && m_count() == 0) m_busy = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("valid", out_valid, m_busy);
        check("busy",  busy,      m_busy);
        check("q",     q,         m_busy ? m_sel() : 0);
        check("count", count,     m_count());
    endtask

    // One clock: drive inputs, check the combinational flag, advance the
    // model, then compare registered outputs 1 ns after the edge.
    task automatic cycle(input bit r, input logic [7:0] dd, input bit ld_i,
                         input bit hd, input bit rd);
        rst_n = r; d = dd; load = ld_i; hold = hd; out_ready = rd;
        #1;
        check("any", any, |dd);
        model_step(r, dd, ld_i, hd, rd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int exp_a;
        int exp_b;
        int exp_c;
        bit r;
        bit ld_r;
        bit hd_r;
        bit rd_r;
        logic [7:0] dd_r;

        rst_n = 1'b0; d = '0; load = 1'b0; hold = 1'b0; out_ready = 1'b0;
        d5 = '0; load5 = 1'b0; hold5 = 1'b0; ready5 = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_busy = 1'b0;
        m_ptr  = 0;

        // Reset state.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("rst.valid", out_valid, 0);
        check("rst.count", count, 0);
        check("rst.q", q, 0);

        // Three-bit drain: q = 2, 5, 7, then empty.
        cycle(1'b1, 8'b1010_0100, 1'b1, 1'b0, 1'b1);
        check("drain.q0", q, 2);
        check("drain.c0", count, 3);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("drain.q1", q, 5);
        check("drain.c1", count, 2);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("drain.q2", q, 7);
        check("drain.c2", count, 1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("drain.valid_end", out_valid, 0);
        check("drain.c3", count, 0);

        // Pop and load in the same cycle.
        cycle(1'b1, 8'b1010_0000, 1'b1, 1'b0, 1'b0);
        check("poplд.q5", q, 5);
        cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        check("popld.q", q, ROT ? 7 : 0);
        check("popld.count", count, 2);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("popld.idle", out_valid, 0);

        // Hold freezes everything, even with ready and an all-ones load.
        cycle(1'b1, 8'b0100_1000, 1'b1, 1'b0, 1'b0);
        check("hold.q_pre", q, 3);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
            check("hold.q", q, 3);
            check("hold.count", count, 2);
        end
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("hold.resume_q", q, 6);
        check("hold.resume_c", count, 1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset mid-drain discards all pending bits.
        cycle(1'b1, 8'b0001_1111, 1'b1, 1'b0, 1'b0);
        check("rstmid.count_pre", count, 5);
        cycle(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1);
        check("rstmid.valid", out_valid, 0);
        check("rstmid.count", count, 0);
        check("rstmid.q", q, 0);

        // Pop index 0 while re-requesting it: order depends on the build.
        cycle(1'b1, 8'b1000_0011, 1'b1, 1'b0, 1'b0);
        check("reld.q0", q, 0);
        exp_a = ROT ? 1 : 0;
        exp_b = ROT ? 7 : 1;
        exp_c = ROT ? 0 : 7;
        cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        check("reld.q1", q, exp_a);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("reld.q2", q, exp_b);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("reld.q3", q, exp_c);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        check("reld.idle", out_valid, 0);

        // Narrow instance: top index stalls, then drains on ready.
        d5 = 5'b10000; load5 = 1'b1;
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        check("w5.any", any5, 1);
        check("w5.valid", valid5, 1);
        check("w5.q", q5, 4);
        check("w5.count", count5, 1);
        d5 = '0; load5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            check("w5.stall_q", q5, 4);
            check("w5.stall_valid", valid5, 1);
        end
        ready5 = 1'b1;
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        check("w5.end_valid", valid5, 0);
        check("w5.end_busy", busy5, 0);
        check("w5.end_count", count5, 0);
        ready5 = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 59) != 0);
            ld_r = ($urandom_range(0, 2) == 0);
            hd_r = ($urandom_range(0, 5) == 0);
            rd_r = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       dd_r = 8'h00;
                1:       dd_r = 8'(1 << $urandom_range(0, 7));
                default: dd_r = 8'($urandom);
            endcase
            cycle(r, dd_r, ld_r, hd_r, rd_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
